ram_rd_stream: RTL and testbench



---
 rtl/ram_rd_pkg.sv | 16 +
 rtl/rd_skid_fifo.sv | 56 +++++
 rtl/ram_rd_stream.sv | 118 +++++++++++
 tb/tb_ram_rd_stream.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_rd_pkg.sv
// Shared types and constants for the RAM read-stream front end.
package ram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } rd_state_t;

  localparam int RD_BUF_DEPTH = 3;

  // Fixed at one cycle: the issue rule budgets exactly one in-flight read,
  // so a deeper RAM pipeline needs that rule reworked.
  localparam int RAM_RD_LATENCY = 1;

endpackage

// File: rtl/rd_skid_fifo.sv
// Three-entry shift-register FIFO; the head sits in entry 0, so the outputs
// come straight from flops.
module rd_skid_fifo
  import ram_rd_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [RD_BUF_DEPTH];
  logic [1:0]       count_nxt;
  logic [1:0]       wr_idx;

  assign count_nxt = count + 2'(push) - 2'(pop);
  // A pop shifts everything down one slot, so the free slot moves with it.
  assign wr_idx    = pop ? count - 2'd1 : count;
  assign head_data = mem[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: entries are reset because entry 0 is the m_data port, which has a defined reset value.
      mem        <= '{default: '0};
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments: a push to the slot a pop is shifting into
      // must override the shift, and the later NBA wins.
      count      <= count_nxt;
      head_valid <= (count_nxt != 2'd0);
      if (pop) begin
        mem[0] <= mem[1];
        mem[1] <= mem[2];
      end
      if (push) begin
        case (wr_idx)
          2'd0:    mem[0] <= push_data;
          2'd1:    mem[1] <= push_data;
          2'd2:    mem[2] <= push_data;
          default: ;
        endcase
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == 2'd3));

endmodule

// File: rtl/ram_rd_stream.sv
// Burst read front end: issues sequential RAM reads and turns the returned
// words into a valid/ready stream with a last marker.
module ram_rd_stream
  import ram_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  ram_rd_req,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  rd_state_t             state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  req_last;
  logic                  inflight;
  logic                  inflight_last;
  logic [1:0]            count;
  logic                  pop;
  logic [2:0]            occ_nxt;
  logic                  can_issue;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign pop       = m_valid & m_ready;

  // ram_rd_req is a flop, so the next request is planned one cycle ahead
  // from the occupancy the buffer will have after this edge.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    occ_nxt   = 3'(count) + 3'(inflight) - 3'(pop);
    can_issue = 1'b0;
    if (remaining != '0)
      can_issue = (occ_nxt + 3'(ram_rd_req)) < 3'(RD_BUF_DEPTH);
  end

  rd_skid_fifo #(.WIDTH(DATA_WIDTH + 1)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight),
    .push_data  ({inflight_last, ram_rd_data}),
    .pop        (pop),
    .head_valid (m_valid),
    .head_data  ({m_last, m_data}),
    .count      (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      req_last      <= 1'b0;
      ram_rd_req    <= 1'b0;
      ram_rd_addr   <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      inflight      <= ram_rd_req;
      inflight_last <= ram_rd_req & req_last;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              state       <= ISSUE;
              ram_rd_req  <= 1'b1;
              ram_rd_addr <= cmd_base_addr;
              req_last    <= (cmd_len == LEN_WIDTH'(1));
              addr        <= cmd_base_addr + ADDR_WIDTH'(1);
              remaining   <= cmd_len - LEN_WIDTH'(1);
            end
          end
        end
        ISSUE: begin
          if (ram_rd_req && req_last) begin
            state      <= DRAIN;
            ram_rd_req <= 1'b0;
          end else if (can_issue) begin
            ram_rd_req  <= 1'b1;
            ram_rd_addr <= addr;
            req_last    <= (remaining == LEN_WIDTH'(1));
            addr        <= addr + ADDR_WIDTH'(1);
            remaining   <= remaining - LEN_WIDTH'(1);
          end else begin
            ram_rd_req <= 1'b0;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_rd_stream.sv
// Directed bench for ram_rd_stream: per-cycle vector table plus hand-written
// backpressure and reset sequences against a registered-read RAM model.
module tb_ram_rd_stream;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_base_addr;
  logic [12:0] cmd_len;
  logic        ram_rd_req;
  logic [11:0] ram_rd_addr;
  logic [9:0]  ram_rd_data;
  logic        m_valid;
  logic        m_ready;
  logic [9:0]  m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  ram_rd_stream #(.DATA_WIDTH(10), .ADDR_WIDTH(12), .LEN_WIDTH(13)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_base_addr (cmd_base_addr),
    .cmd_len       (cmd_len),
    .ram_rd_req    (ram_rd_req),
    .ram_rd_addr   (ram_rd_addr),
    .ram_rd_data   (ram_rd_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Low addresses hold their own value; the top two address bits are folded
  // into the data so a wrong high address bit shows up in the data.
  function automatic logic [9:0] mem_val(input int a);
    logic [11:0] i;
    i = 12'(a);
    return i[9:0] ^ {i[11:10], 8'h00};
  endfunction

  logic [9:0] ram [4096];
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = mem_val(i);
    ram_rd_data = '0;
  end
  always @(posedge clk) if (ram_rd_req) ram_rd_data <= ram[ram_rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        cv;
    logic [11:0] base;
    logic [12:0] len;
    logic        rdy;
    logic        e_cr;
    logic        e_req;
    logic [11:0] e_addr;
    logic        e_mv;
    logic [9:0]  e_data;
    logic        e_last;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t tbl [18];

  task automatic send_cmd(input logic [11:0] base, input logic [12:0] len);
    check("cmd_ready before cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_base_addr = base; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Called at the negedge of the first request cycle; follows the stream
  // until done, or until abort_after beats have been accepted.
  task automatic collect(input logic [11:0] base, input int len, input bit rnd, input int abort_after);
    int         beats = 0;
    int         issued = 0;
    bit         stalled = 0;
    bit         got_done = 0;
    logic [10:0] held = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (got_done || (abort_after > 0 && beats == abort_after)) break;
      if (ram_rd_req) issued++;
      check("outstanding<=3", 32'(issued - beats <= 3), 32'd1);
      if (stalled) check("stall hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, held}));
      if (done) begin
        got_done = 1;
        check("no beat with done", 32'(m_valid), 32'd0);
      end
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 1'b0;
      if (m_valid) begin
        if (m_ready) begin
          check("beat data", 32'(m_data), 32'(mem_val(int'(base) + beats)));
          check("beat last", 32'(m_last), 32'(beats == len - 1));
          beats++;
        end else begin
          stalled = 1'b1;
          held    = {m_last, m_data};
        end
      end
      @(negedge clk);
    end
    m_ready = 1'b1;
    if (abort_after == 0) begin
      check("done seen", 32'(got_done), 32'd1);
      check("beat count", 32'(beats), 32'(len));
      check("reads issued", 32'(issued), 32'(len));
    end else begin
      check("beats before abort", 32'(beats), 32'(abort_after));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, " ram_rd_req"}, 32'(ram_rd_req), 32'd0);
    check({tag, " ram_rd_addr"}, 32'(ram_rd_addr), 32'd0);
    check({tag, " m_valid"}, 32'(m_valid), 32'd0);
    check({tag, " m_data"}, 32'(m_data), 32'd0);
    check({tag, " m_last"}, 32'(m_last), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
  endtask

  initial begin
    //            cv  base     len    rdy cr req addr     mv data    lst bsy dn
    tbl[0]  = '{1'b1, 12'h010, 13'd4, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 12'h000, 13'd0, 1'b1, 1'b0, 1'b1, 12'h010, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 12'h000, 13'd0, 1'b1, 1'b0, 1'b1, 12'h011, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 12'h000, 13'd0, 1'b1, 1'b0, 1'b1, 12'h012, 1'b1, 10'h010, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 12'h000, 13'd0, 1'b1, 1'b0, 1'b1, 12'h013, 1'b1, 10'h011, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 12'h000, 13'd0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 10'h012, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 12'h000, 13'd0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 10'h013, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 12'h123, 13'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 12'h000, 13'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 12'hFFE, 13'd4, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 12'h000, 13'd0, 1'b1, 1'b0, 1'b1, 12'hFFE, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 12'h555, 13'd2, 1'b1, 1'b0, 1'b1, 12'hFFF, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 12'h555, 13'd2, 1'b1, 1'b0, 1'b1, 12'h000, 1'b1, 10'h0FE, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 12'h000, 13'd0, 1'b1, 1'b0, 1'b1, 12'h001, 1'b1, 10'h0FF, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 12'h000, 13'd0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 10'h000, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 12'h000, 13'd0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 10'h001, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 12'h000, 13'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 12'h000, 13'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_base_addr = '0; cmd_len = '0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic burst, zero-length at the done cycle, wrap burst with an ignored command.
    for (int i = 0; i < 18; i++) begin
      check($sformatf("v%0d cmd_ready", i), 32'(cmd_ready), 32'(tbl[i].e_cr));
      check($sformatf("v%0d ram_rd_req", i), 32'(ram_rd_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) check($sformatf("v%0d ram_rd_addr", i), 32'(ram_rd_addr), 32'(tbl[i].e_addr));
      check($sformatf("v%0d m_valid", i), 32'(m_valid), 32'(tbl[i].e_mv));
      if (tbl[i].e_mv) begin
        check($sformatf("v%0d m_data", i), 32'(m_data), 32'(tbl[i].e_data));
        check($sformatf("v%0d m_last", i), 32'(m_last), 32'(tbl[i].e_last));
      end
      check($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("v%0d done", i), 32'(done), 32'(tbl[i].e_done));
      cmd_valid = tbl[i].cv; cmd_base_addr = tbl[i].base; cmd_len = tbl[i].len;
      m_ready = tbl[i].rdy;
      @(negedge clk);
    end
    cmd_valid = 1'b0;

    // Random backpressure.
    send_cmd(12'h020, 13'd8);
    collect(12'h020, 8, 1'b1, 0);
    repeat (2) @(negedge clk);

    // Reset after three of six beats, then a fresh short burst.
    send_cmd(12'h040, 13'd6);
    collect(12'h040, 6, 1'b0, 3);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid-burst reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("post-reset quiet", 32'({m_valid, done, ram_rd_req, busy}), 32'd0);
      @(negedge clk);
    end
    send_cmd(12'h050, 13'd2);
    collect(12'h050, 2, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
